// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace buffer.
//   - FSM state encodings
//   - entry_w(): width of one stored trace entry {timestamp, stage_valid, stage_data}
//   - ptr_w():   width of a buffer index for a given depth
package pipe_trace_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic int entry_w(input int ts_w, input int stages, input int data_w);
    return ts_w + stages * (data_w + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// trace_ram: DEPTH x WIDTH storage for trace entries.
//   i_clk              write clock
//   i_we/i_waddr/i_wdata  synchronous write port
//   i_raddr/o_rdata    asynchronous read port
// Contents are intentionally not reset.
module trace_ram
  import pipe_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [WIDTH-1:0]          o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular trace capture of per-stage pipeline probes with a
// timestamp. Capture is armed, runs until POST_TRIG entries after the trigger
// entry, then the frozen window is drained oldest-first over a valid/ready port.
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_stage_data/valid  probe words and per-stage qualifiers
//   i_arm, i_trigger    start capture / level trigger (sampled while ARMED)
//   i_clear             synchronous abort to IDLE
//   i_rd_ready          consumer ready
//   o_rd_valid/o_rd_data  readout entry {timestamp, stage_valid, stage_data}
//   o_busy, o_done      ARMED or POST / DONE
//   o_wrapped           pre-trigger history was overwritten
//   o_trig_pos          trigger entry index in readout order
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STAGES      = 5,
  parameter int DEPTH       = 32,
  parameter int POST_TRIG   = 8,
  parameter int TS_W        = 16,
  parameter int CAPTURE_ALL = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic [STAGES*DATA_W-1:0]                i_stage_data,
  input  logic [STAGES-1:0]                       i_stage_valid,
  input  logic                                    i_arm,
  input  logic                                    i_trigger,
  input  logic                                    i_clear,
  input  logic                                    i_rd_ready,
  output logic                                    o_rd_valid,
  output logic [entry_w(TS_W, STAGES, DATA_W)-1:0] o_rd_data,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_wrapped,
  output logic [ptr_w(DEPTH)-1:0]                 o_trig_pos
);

  localparam int ENTRY_W = entry_w(TS_W, STAGES, DATA_W);
  localparam int PTR_W   = ptr_w(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);

  logic [1:0]         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, r_post_cnt, r_trig_idx, r_trig_pos;
  logic [CNT_W-1:0]   r_count, r_remaining;
  logic               r_wrapped;
  logic [TS_W-1:0]    r_ts;

  logic               w_write_q, w_we, w_trig_hit, w_post_last, w_xfer, w_last_xfer;
  logic               w_enter_done, w_wrapped_nxt;
  logic [PTR_W-1:0]   w_wr_ptr_nxt, w_trig_idx_nxt, w_oldest;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ENTRY_W-1:0] w_wr_entry, w_rd_data;

  assign w_write_q   = (CAPTURE_ALL != 0) ? 1'b1 : |i_stage_valid;
  assign w_trig_hit  = (r_state == ARMED) && i_trigger && !i_clear;
  // The trigger cycle always writes so the trigger entry exists even if no stage is valid.
  assign w_we        = !i_clear && (((r_state == ARMED) && (w_write_q || i_trigger)) ||
                                    ((r_state == POST) && w_write_q));
  assign w_post_last = (r_state == POST) && w_write_q && (r_post_cnt == PTR_W'(1));
  assign w_xfer      = o_rd_valid && i_rd_ready;
  assign w_last_xfer = w_xfer && (r_remaining == CNT_W'(1));
  assign w_wr_entry  = {r_ts, i_stage_valid, i_stage_data};

  // Post-write view of the capture pointers, used to freeze the window on DONE entry.
  assign w_wr_ptr_nxt   = w_we ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
  assign w_count_nxt    = (w_we && (r_count != CNT_FULL)) ? r_count + CNT_W'(1) : r_count;
  assign w_wrapped_nxt  = r_wrapped || (w_we && (r_count == CNT_FULL));
  assign w_trig_idx_nxt = w_trig_hit ? r_wr_ptr : r_trig_idx;
  assign w_oldest       = w_wrapped_nxt ? w_wr_ptr_nxt : '0;
  assign w_enter_done   = (r_state != DONE) && (w_state_nxt == DONE);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_arm) w_state_nxt = ARMED;
        ARMED:   if (i_trigger) w_state_nxt = (POST_TRIG == 0) ? DONE : POST;
        POST:    if (w_post_last) w_state_nxt = DONE;
        DONE:    if (w_last_xfer) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_busy     = (r_state == ARMED) || (r_state == POST);
    o_done     = (r_state == DONE);
    o_rd_valid = o_done && (r_remaining != '0);
    o_rd_data  = o_rd_valid ? w_rd_data : '0;
    o_wrapped  = r_wrapped;
    o_trig_pos = r_trig_pos;
  end

  // Pointers, counters and timestamp
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_remaining <= '0;
      r_trig_idx  <= '0;
      r_trig_pos  <= '0;
      r_wrapped   <= 1'b0;
      r_ts        <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (i_clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_post_cnt  <= '0;
        r_remaining <= '0;
        r_trig_idx  <= '0;
        r_trig_pos  <= '0;
        r_wrapped   <= 1'b0;
      end else begin
        if ((r_state == IDLE) && i_arm) begin
          r_wr_ptr  <= '0;
          r_count   <= '0;
          r_wrapped <= 1'b0;
        end else if (w_we) begin
          r_wr_ptr  <= w_wr_ptr_nxt;
          r_count   <= w_count_nxt;
          r_wrapped <= w_wrapped_nxt;
        end

        if (w_trig_hit) begin
          r_trig_idx <= r_wr_ptr;
          r_post_cnt <= POST_INIT;
        end else if ((r_state == POST) && w_write_q) begin
          r_post_cnt <= r_post_cnt - PTR_W'(1);
        end

        if (w_enter_done) begin
          r_rd_ptr    <= w_oldest;
          r_remaining <= w_count_nxt;
          r_trig_pos  <= w_trig_idx_nxt - w_oldest;
        end else if (w_xfer) begin
          r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
          r_remaining <= r_remaining - CNT_W'(1);
        end
      end
    end
  end

  trace_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer. Two instances share stimulus: index 0 captures
// every cycle, index 1 captures only cycles with a valid stage. A queue-based
// model of the captured window predicts every output each cycle.
module tb_pipe_trace_buffer;

  localparam int DATA_W = 16;
  localparam int STAGES = 5;
  localparam int DEPTH  = 8;
  localparam int POST_T = 3;
  localparam int TS_W   = 16;
  localparam int EW     = TS_W + STAGES * (DATA_W + 1);

  logic                       clk;
  logic                       reset;
  logic [STAGES*DATA_W-1:0]   stage_data;
  logic [STAGES-1:0]          stage_valid;
  logic                       arm, trigger, clear, rd_ready;

  logic [1:0]    d_valid, d_busy, d_done, d_wrapped;
  logic [2:0]    d_tp   [2];
  logic [EW-1:0] d_data [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int            m_state [2];  // 0 idle, 1 armed, 2 post, 3 done
  logic [EW-1:0] mq      [2][$];
  bit            m_wrapped [2];
  int            m_trig  [2];
  int            m_tp    [2];
  int            m_post  [2];
  logic [TS_W-1:0] m_ts;

  pipe_trace_buffer #(
    .DATA_W(DATA_W), .STAGES(STAGES), .DEPTH(DEPTH), .POST_TRIG(POST_T),
    .TS_W(TS_W), .CAPTURE_ALL(1)
  ) dut_all (
    .i_clk(clk), .i_reset(reset), .i_stage_data(stage_data), .i_stage_valid(stage_valid),
    .i_arm(arm), .i_trigger(trigger), .i_clear(clear), .i_rd_ready(rd_ready),
    .o_rd_valid(d_valid[0]), .o_rd_data(d_data[0]), .o_busy(d_busy[0]), .o_done(d_done[0]),
    .o_wrapped(d_wrapped[0]), .o_trig_pos(d_tp[0])
  );

  pipe_trace_buffer #(
    .DATA_W(DATA_W), .STAGES(STAGES), .DEPTH(DEPTH), .POST_TRIG(POST_T),
    .TS_W(TS_W), .CAPTURE_ALL(0)
  ) dut_vld (
    .i_clk(clk), .i_reset(reset), .i_stage_data(stage_data), .i_stage_valid(stage_valid),
    .i_arm(arm), .i_trigger(trigger), .i_clear(clear), .i_rd_ready(rd_ready),
    .o_rd_valid(d_valid[1]), .o_rd_data(d_data[1]), .o_busy(d_busy[1]), .o_done(d_done[1]),
    .o_wrapped(d_wrapped[1]), .o_trig_pos(d_tp[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- model ----------------
  task automatic m_reset_all();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; mq[i].delete(); m_wrapped[i] = 0;
      m_trig[i] = 0; m_tp[i] = 0; m_post[i] = 0;
    end
    m_ts = '0;
  endtask

  task automatic m_push(input int i, input logic [EW-1:0] e);
    mq[i].push_back(e);
    if (mq[i].size() > DEPTH) begin
      void'(mq[i].pop_front());
      m_wrapped[i] = 1;
      m_trig[i]--;
    end
  endtask

  task automatic m_step(input int i);
    bit wq;
    logic [EW-1:0] e;
    wq = (i == 0) ? 1'b1 : (stage_valid != '0);
    e  = {m_ts, stage_valid, stage_data};
    if (clear) begin
      m_state[i] = 0; mq[i].delete(); m_wrapped[i] = 0; m_tp[i] = 0;
    end else begin
      case (m_state[i])
        0: if (arm) begin m_state[i] = 1; mq[i].delete(); m_wrapped[i] = 0; end
        1: if (trigger || wq) begin
          m_push(i, e);
          if (trigger) begin
            m_trig[i] = mq[i].size() - 1;
            m_post[i] = POST_T;
            if (POST_T == 0) begin m_state[i] = 3; m_tp[i] = m_trig[i]; end
            else m_state[i] = 2;
          end
        end
        2: if (wq) begin
          m_push(i, e);
          m_post[i]--;
          if (m_post[i] == 0) begin m_state[i] = 3; m_tp[i] = m_trig[i]; end
        end
        default: if (mq[i].size() != 0 && rd_ready) begin
          void'(mq[i].pop_front());
          if (mq[i].size() == 0) m_state[i] = 0;
        end
      endcase
    end
  endtask

  initial begin
    m_reset_all();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset_all();
      else begin
        for (int i = 0; i < 2; i++) m_step(i);
        m_ts = m_ts + 16'd1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          bit ev;
          ev = (m_state[i] == 3) && (mq[i].size() != 0);
          chk($sformatf("busy[%0d]", i), d_busy[i], (m_state[i] == 1 || m_state[i] == 2));
          chk($sformatf("done[%0d]", i), d_done[i], m_state[i] == 3);
          chk($sformatf("rd_valid[%0d]", i), d_valid[i], ev);
          chk($sformatf("wrapped[%0d]", i), d_wrapped[i], m_wrapped[i]);
          chk($sformatf("trig_pos[%0d]", i), d_tp[i], m_tp[i][2:0]);
          if (ev) chk($sformatf("rd_data[%0d]", i), d_data[i], mq[i][0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit a, input bit t, input bit c, input bit r,
                      input logic [4:0] v, input logic [15:0] d0);
    arm = a; trigger = t; clear = c; rd_ready = r; stage_valid = v;
    stage_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), d0};
    @(negedge clk);
  endtask

  logic [TS_W-1:0] trig_ts, first_ts;
  logic [EW-1:0]   ent;

  initial begin
    reset = 1'b1; arm = 0; trigger = 0; clear = 0; rd_ready = 0;
    stage_valid = '0; stage_data = '0;
    #1;
    chk("reset_busy", d_busy[0], 0);
    chk("reset_done", d_done[0], 0);
    chk("reset_rd_valid", d_valid[0], 0);
    chk("reset_trig_pos", d_tp[0], 0);
    chk("reset_rd_data", d_data[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Two pre-trigger entries, trigger, three post entries.
    tick(1, 0, 0, 0, 5'h1f, 16'd99);
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 5'h1f, 16'(k));
    tick(0, 1, 0, 0, 5'h1f, 16'd2);
    for (int k = 3; k < 6; k++) tick(0, 0, 0, 0, 5'h1f, 16'(k));
    chk("t2_done", d_done[0], 1);
    chk("t2_trig_pos", d_tp[0], 3'd2);
    chk("t2_wrapped", d_wrapped[0], 0);
    for (int k = 0; k < 6; k++) begin
      ent = d_data[0];
      chk("t2_order", ent[15:0], 16'(k));
      tick(0, 0, 0, 1, 5'h1f, 16'd0);
    end
    chk("t2_idle", d_done[0], 0);

    // Long pre-trigger history wraps; readout with toggling ready.
    tick(1, 0, 0, 0, 5'h1f, 16'd0);
    for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 5'h1f, 16'(k));
    trig_ts = m_ts;
    tick(0, 1, 0, 0, 5'h1f, 16'd20);
    for (int k = 21; k < 24; k++) tick(0, 0, 0, 0, 5'h1f, 16'(k));
    chk("t3_wrapped", d_wrapped[0], 1);
    chk("t3_trig_pos", d_tp[0], 3'd4);
    ent = d_data[0];
    chk("t3_first_ts", ent[EW-1 -: TS_W], trig_ts - 16'd4);
    chk("t3_first_idx", ent[15:0], 16'd16);
    for (int k = 0; k < 16; k++) tick(0, 0, 0, (k % 2) == 0, 5'h1f, 16'd0);
    chk("t5_idle", d_done[0], 0);

    // Gap of idle probe cycles is skipped when capturing only valid stages.
    tick(1, 0, 0, 0, 5'h00, 16'd0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 5'h00, 16'(50 + k));
    first_ts = m_ts;
    tick(0, 0, 0, 0, 5'h01, 16'd100);
    tick(0, 0, 0, 0, 5'h01, 16'd101);
    tick(0, 1, 0, 0, 5'h01, 16'd102);
    for (int k = 3; k < 6; k++) tick(0, 0, 0, 0, 5'h01, 16'(100 + k));
    chk("t4_vld_done", d_done[1], 1);
    chk("t4_vld_trig_pos", d_tp[1], 3'd2);
    chk("t4_vld_wrapped", d_wrapped[1], 0);
    ent = d_data[1];
    chk("t4_vld_first_ts", ent[EW-1 -: TS_W], first_ts);
    chk("t4_vld_first_idx", ent[15:0], 16'd100);
    chk("t4_all_trig_pos", d_tp[0], 3'd4);
    chk("t4_all_wrapped", d_wrapped[0], 1);
    for (int k = 0; k < 10; k++) tick(0, 0, 0, 1, 5'h00, 16'd0);
    chk("t4_idle_all", d_done[0], 0);
    chk("t4_idle_vld", d_done[1], 0);

    // Clear in DONE with three entries left, then re-arm.
    tick(1, 0, 0, 0, 5'h1f, 16'd0);
    tick(0, 0, 0, 0, 5'h1f, 16'd0);
    tick(0, 1, 0, 0, 5'h1f, 16'd1);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 5'h1f, 16'(2 + k));
    tick(0, 0, 0, 1, 5'h1f, 16'd0);
    tick(0, 0, 0, 1, 5'h1f, 16'd0);
    chk("t6_done_before", d_done[0], 1);
    tick(0, 0, 1, 0, 5'h1f, 16'd0);
    chk("t6_done_after", d_done[0], 0);
    chk("t6_valid_after", d_valid[0], 0);
    tick(1, 0, 0, 0, 5'h1f, 16'd0);
    chk("t6_rearm", d_busy[0], 1);

    // Asynchronous reset while in POST.
    tick(0, 1, 0, 0, 5'h1f, 16'd0);
    chk("t1_in_post", d_busy[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_busy", d_busy[0], 0);
    chk("t1_done", d_done[0], 0);
    chk("t1_rd_valid", d_valid[0], 0);
    chk("t1_busy_vld", d_busy[1], 0);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] v;
      v = ($urandom_range(0, 2) == 0) ? 5'h00 : 5'($urandom);
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 1) == 1, v, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Parametrised on-chip trace capture buffer for the pipelined CPU. It records per-stage snapshots (IF, ID, EX, M, WB or any STAGES count) into a circular buffer with a timestamp. Capture freezes a programmable number of entries after a trigger. The frozen window is then drained through a valid/ready port. It replaces cycle-by-cycle simulation printing with synthesizable, window-based observation that sits beside the cpu top level.

Parameters:
DATA_W, 16, width of one stage probe word
STAGES, 5, number of probed pipeline stages
DEPTH, 32, trace entries; power of two, >= 4
POST_TRIG, 8, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1
TS_W, 16, timestamp width
CAPTURE_ALL, 0, 1 = write every cycle; 0 = write only when any stage_valid bit is set

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stage_data  in  STAGES*DATA_W  probe words; stage s occupies bits [s*DATA_W +: DATA_W]
stage_valid  in  STAGES  per-stage valid qualifier
arm  in  1  single-cycle pulse that starts capture
trigger  in  1  level trigger, sampled only while ARMED
clear  in  1  synchronous abort to IDLE
rd_ready  in  1  consumer ready
rd_valid  out  1  rd_data is valid
rd_data  out  TS_W+STAGES*(DATA_W+1)  entry: {timestamp, stage_valid, stage_data}
busy  out  1  state is ARMED or POST
done  out  1  state is DONE
wrapped  out  1  pre-trigger history was overwritten (count reached DEPTH)
trig_pos  out  $clog2(DEPTH)  index of the trigger entry in readout order

Behaviour:
- Reset (asynchronous): state=IDLE; wr_ptr, rd_ptr, count, post_cnt, remaining, trig_pos, ts = 0; all outputs 0. RAM contents are not reset.
- ts is a free-running TS_W counter that wraps modulo 2^TS_W. An entry stores the ts value of its write cycle.
- write_q = CAPTURE_ALL ? 1 : |stage_valid. An entry is written only in ARMED or POST.
- IDLE: arm -> ARMED, with wr_ptr=0, count=0, wrapped=0. trigger is ignored.
- ARMED: on write_q, write at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH. count saturates at DEPTH; wrapped=1 when a write occurs with count==DEPTH. A trigger cycle always writes, even when write_q=0. That entry is the trigger entry, trig_idx=wr_ptr. If POST_TRIG==0 -> DONE, else post_cnt=POST_TRIG -> POST.
- POST: each write_q write decrements post_cnt. The write that takes post_cnt to 0 -> DONE on the next edge. trigger is ignored.
- DONE entry: oldest = wrapped ? wr_ptr : 0; rd_ptr=oldest; remaining=min(count,DEPTH); trig_pos = trig_idx - oldest mod DEPTH. No writes occur in DONE.
- DONE readout: rd_valid = (remaining != 0). rd_data = RAM[rd_ptr] combinationally. A transfer occurs when rd_valid & rd_ready: rd_ptr+1 mod DEPTH, remaining-1. The transfer that brings remaining to 0 -> IDLE on the same edge, and done drops.
- clear takes priority over all other inputs: next state IDLE, pointers and counters zeroed, wrapped=0.
- arm in any state other than IDLE is ignored. arm and trigger asserted in the same cycle in IDLE: arm only.
- Latency: a probe on cycle n becomes readable from DONE onward. There is 0 cycles read latency, so back-to-back transfers are allowed.
- Reset during any state aborts immediately, and the next readout starts empty.

Decomposition:
- Package pipe_trace_pkg holds:
  - state localparams IDLE=2'd0, ARMED=2'd1, POST=2'd2, DONE=2'd3;
  - entry-width function TS_W+STAGES*(DATA_W+1);
  - pointer width $clog2(DEPTH).
- Sub-module trace_ram: DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port, no reset.
- The FSM, pointers and timestamp stay in pipe_trace_buffer.

Test Plan (DATA_W=16, STAGES=5, DEPTH=8, POST_TRIG=3, CAPTURE_ALL=1 unless stated):
1. Reset mid-POST: assert reset asynchronously -> busy=0, done=0, rd_valid=0 immediately, with no clock edge needed.
2. arm, 2 cycles, trigger, then 3 cycles, with stage_data[15:0]=cycle index -> done after 6 writes; 6 entries read in order; trig_pos=2; wrapped=0.
3. arm, 20 cycles, trigger -> wrapped=1; 8 entries read; first timestamp = trigger ts - 4; trig_pos=4.
4. CAPTURE_ALL=0, stage_valid=0 for 5 cycles then 5'b00001 each cycle, then trigger -> idle cycles not stored; timestamps non-contiguous across the gap.
5. Readout with rd_ready toggling 1,0,1,0 -> each entry transferred exactly once; rd_data held while rd_ready=0; return to IDLE after last transfer.
6. clear asserted during DONE with remaining=3 -> IDLE next edge, rd_valid=0; a following arm is accepted.
